// File: rtl/uart_tx_serializer_pkg.sv
// Shared definitions for the UART transmit path: FSM states, parity modes,
// line idle level and the frame-length helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam logic UART_IDLE_LVL = 1'b1;

    // Bit periods per frame: start + data + optional parity + stop bits.
    function automatic int frame_len(input int data_w, input int parity_mode,
                                     input int stop_bits);
        return 1 + data_w + ((parity_mode != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_parity_gen.sv
// Combinational parity for one data word; order-independent, so it is fed
// the raw word and its result is loaded behind the data in the shift register.
module uart_parity_gen
    import uart_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int PARITY_MODE = PAR_EVEN
) (
    input  logic [DATA_W-1:0] data,
    output logic              parity
);

    if (PARITY_MODE < PAR_NONE || PARITY_MODE > PAR_ODD) begin : g_bad_mode
        $error("uart_parity_gen: PARITY_MODE must be 0, 1 or 2");
    end

    assign parity = (PARITY_MODE == PAR_ODD)  ? ~(^data) :
                    (PARITY_MODE == PAR_EVEN) ?  (^data) : 1'b0;

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: one word per handshake, one frame bit per baud_clk
// cycle on serial_tx, with back-to-back frames and no idle gap between them.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int PARITY_MODE = PAR_NONE,
    parameter int STOP_BITS   = 1,
    parameter int LSB_FIRST   = 1
) (
    input  logic              baud_clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              serial_tx,
    output logic              busy,
    output logic              frame_done,
    output uart_state_e       dbg_state
);

    if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
        $error("uart_tx_serializer: DATA_W must be in 5..9");
    end
    if (PARITY_MODE < PAR_NONE || PARITY_MODE > PAR_ODD) begin : g_bad_parity
        $error("uart_tx_serializer: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
    end

    localparam int                CNT_W     = $clog2(DATA_W);
    localparam int                SR_W      = DATA_W + 1;
    localparam logic [CNT_W-1:0]  LAST_DATA = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  LAST_STOP = CNT_W'(STOP_BITS - 1);
    localparam bit                HAS_PAR   = (PARITY_MODE != PAR_NONE);

    uart_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic              serial_tx_q, serial_tx_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;

    logic [DATA_W-1:0] data_ord;
    logic              par_bit;
    logic              last_stop;
    logic              accept;

    uart_parity_gen #(
        .DATA_W      (DATA_W),
        .PARITY_MODE (PARITY_MODE)
    ) u_parity_gen (
        .data   (tx_data),
        .parity (par_bit)
    );

    // Shift register always shifts out bit 0, so the word is reordered at load.
    always_comb begin
        data_ord = '0;
        for (int i = 0; i < DATA_W; i++) begin
            data_ord[i] = (LSB_FIRST != 0) ? tx_data[i] : tx_data[DATA_W-1-i];
        end
    end

    // Handshake: a word transfers on a rising baud_clk edge where tx_valid and
    // tx_ready are both 1; the producer holds tx_valid/tx_data until then.
    assign last_stop = (state_q == ST_STOP) && (cnt_q == LAST_STOP);
    assign tx_ready  = rst & ((state_q == ST_IDLE) | last_stop);
    assign accept    = tx_valid & tx_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        serial_tx_d = serial_tx_q;
        unique case (state_q)
            ST_IDLE: begin
                serial_tx_d = UART_IDLE_LVL;
                if (accept) begin
                    state_d     = ST_START;
                    cnt_d       = '0;
                    sr_d        = {par_bit, data_ord};
                    serial_tx_d = 1'b0;
                end
            end
            ST_START: begin
                state_d     = ST_DATA;
                cnt_d       = '0;
                serial_tx_d = sr_q[0];
                sr_d        = {1'b0, sr_q[SR_W-1:1]};
            end
            ST_DATA: begin
                serial_tx_d = sr_q[0];
                sr_d        = {1'b0, sr_q[SR_W-1:1]};
                if (cnt_q == LAST_DATA) begin
                    cnt_d = '0;
                    if (HAS_PAR) begin
                        state_d = ST_PARITY;
                    end else begin
                        state_d     = ST_STOP;
                        serial_tx_d = UART_IDLE_LVL;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PARITY: begin
                state_d     = ST_STOP;
                cnt_d       = '0;
                serial_tx_d = UART_IDLE_LVL;
            end
            ST_STOP: begin
                serial_tx_d = UART_IDLE_LVL;
                if (cnt_q == LAST_STOP) begin
                    cnt_d = '0;
                    if (accept) begin
                        state_d     = ST_START;
                        sr_d        = {par_bit, data_ord};
                        serial_tx_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cnt_d       = '0;
                serial_tx_d = UART_IDLE_LVL;
            end
        endcase
        busy_d       = (state_d != ST_IDLE);
        frame_done_d = (state_d == ST_STOP) && (cnt_d == LAST_STOP);
    end

    always_ff @(posedge baud_clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            sr_q         <= '0;
            serial_tx_q  <= UART_IDLE_LVL;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sr_q         <= sr_d;
            serial_tx_q  <= serial_tx_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign serial_tx  = serial_tx_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: three parameter sets side by side, frames
// predicted at send time and checked bit-by-bit by a line monitor.
module tb_uart_tx_serializer;
    import uart_pkg::*;

    localparam int NCFG = 3;
    localparam int DW_A [NCFG] = '{8, 7, 9};
    localparam int PM_A [NCFG] = '{PAR_NONE, PAR_ODD, PAR_EVEN};
    localparam int SB_A [NCFG] = '{1, 2, 1};
    localparam int LF_A [NCFG] = '{1, 0, 1};
    localparam int FL   [NCFG] = '{frame_len(8, PAR_NONE, 1),
                                   frame_len(7, PAR_ODD, 2),
                                   frame_len(9, PAR_EVEN, 1)};

    logic        baud_clk;
    logic        rst;
    logic [8:0]  tx_data_a  [NCFG];
    logic        tx_valid_a [NCFG];
    logic        rdy_a      [NCFG];
    logic        line_a     [NCFG];
    logic        busy_a     [NCFG];
    logic        fd_a       [NCFG];
    uart_state_e dbg_a      [NCFG];

    logic [15:0] exp_q [NCFG][$];
    int          pos   [NCFG];
    logic [15:0] got   [NCFG];
    int          n_vec = 0;
    int          n_err = 0;

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        uart_tx_serializer #(
            .DATA_W      (DW_A[g]),
            .PARITY_MODE (PM_A[g]),
            .STOP_BITS   (SB_A[g]),
            .LSB_FIRST   (LF_A[g])
        ) u_dut (
            .baud_clk   (baud_clk),
            .rst        (rst),
            .tx_data    (tx_data_a[g][DW_A[g]-1:0]),
            .tx_valid   (tx_valid_a[g]),
            .tx_ready   (rdy_a[g]),
            .serial_tx  (line_a[g]),
            .busy       (busy_a[g]),
            .frame_done (fd_a[g]),
            .dbg_state  (dbg_a[g])
        );
    end

    initial baud_clk = 1'b0;
    always #5 baud_clk = ~baud_clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference frame, bit i = line value in the i-th cycle after accept.
    function automatic logic [15:0] model_frame(input int cfg, input logic [8:0] d);
        logic [15:0] f;
        int          dw;
        int          ones;
        f    = '1;
        dw   = DW_A[cfg];
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < dw; i++) begin
            f[1+i] = (LF_A[cfg] != 0) ? d[i] : d[dw-1-i];
            ones   = ones + int'(d[i]);
        end
        if (PM_A[cfg] == PAR_EVEN) f[1+dw] = (ones % 2 == 1);
        if (PM_A[cfg] == PAR_ODD)  f[1+dw] = (ones % 2 == 0);
        return f;
    endfunction

    function automatic logic [15:0] frame_mask(input int cfg);
        logic [15:0] m;
        m = '0;
        for (int i = 0; i < FL[cfg]; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Monitor: idle cycles must show a quiet line; frames are assembled and
    // compared against the oldest prediction when their last bit is seen.
    always @(negedge baud_clk) begin
        logic        last;
        logic [15:0] e;
        for (int g = 0; g < NCFG; g++) begin
            if (!rst) begin
                pos[g] = 0;
            end else if (pos[g] == 0 && !busy_a[g]) begin
                check($sformatf("idle_c%0d", g),
                      {12'd0, busy_a[g], fd_a[g], rdy_a[g], line_a[g]}, 16'h0003);
            end else begin
                if (pos[g] == 0) got[g] = '1;
                got[g][pos[g]] = line_a[g];
                last = (pos[g] == FL[g] - 1);
                check($sformatf("ctl_c%0d_b%0d", g, pos[g]),
                      {13'd0, busy_a[g], fd_a[g], rdy_a[g]}, {13'd0, 1'b1, last, last});
                if (last) begin
                    if (exp_q[g].size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_frame_c%0d: got %h expected no frame",
                                 g, got[g] & frame_mask(g));
                    end else begin
                        e = exp_q[g].pop_front();
                        check($sformatf("frame_c%0d", g), got[g] & frame_mask(g),
                              e & frame_mask(g));
                    end
                    pos[g] = 0;
                end else begin
                    pos[g]++;
                end
            end
        end
    end

    task automatic send(input int cfg, input logic [8:0] d, input logic [15:0] exp,
                        output time acc_t);
        int n;
        @(negedge baud_clk);
        tx_valid_a[cfg] = 1'b1;
        tx_data_a[cfg]  = d;
        n = 0;
        while (!rdy_a[cfg] && n < 60) begin
            @(negedge baud_clk);
            n++;
        end
        n_vec++;
        acc_t = 0;
        if (!rdy_a[cfg]) begin
            n_err++;
            $display("FAIL accept_timeout_c%0d: got tx_ready 0 expected 1", cfg);
            tx_valid_a[cfg] = 1'b0;
        end else begin
            exp_q[cfg].push_back(exp);
            @(posedge baud_clk);
            acc_t = $time;
        end
    endtask

    task automatic drop(input int cfg);
        @(negedge baud_clk);
        tx_valid_a[cfg] = 1'b0;
    endtask

    task automatic wait_drain();
        int  n;
        bit  pending;
        n = 0;
        pending = 1'b1;
        while (pending && n < 400) begin
            @(negedge baud_clk);
            n++;
            pending = 1'b0;
            for (int g = 0; g < NCFG; g++) begin
                if (exp_q[g].size() != 0 || busy_a[g]) pending = 1'b1;
            end
        end
        for (int g = 0; g < NCFG; g++) begin
            check($sformatf("drain_c%0d", g), 16'(exp_q[g].size()), 16'd0);
        end
        repeat (3) @(negedge baud_clk);
    endtask

    initial begin
        time t0, t1, t2;
        logic [8:0] d;
        rst = 1'b0;
        for (int g = 0; g < NCFG; g++) begin
            tx_valid_a[g] = 1'b0;
            tx_data_a[g]  = '0;
            pos[g]        = 0;
            got[g]        = '1;
        end
        repeat (2) @(negedge baud_clk);
        for (int g = 0; g < NCFG; g++) begin
            check($sformatf("reset_c%0d", g),
                  {11'd0, dbg_a[g] == ST_IDLE, busy_a[g], fd_a[g], rdy_a[g], line_a[g]},
                  16'h0011);
        end
        rst = 1'b1;
        @(negedge baud_clk);

        // Known frames straight from the frame-format rules.
        send(0, 9'h0A5, 16'h034A, t0);
        drop(0);
        send(0, 9'h05A, model_frame(0, 9'h05A), t0);
        drop(0);
        repeat (2) @(negedge baud_clk);
        tx_valid_a[0] = 1'b1;
        tx_data_a[0]  = 9'h00F;
        @(negedge baud_clk);
        tx_valid_a[0] = 1'b0;

        send(0, 9'h000, 16'h0200, t1);
        send(0, 9'h0FF, 16'h03FE, t2);
        drop(0);
        check("b2b_spacing", 16'(t2 - t1), 16'(FL[0] * 10));

        send(1, 9'h055, 16'h07AA, t0);
        drop(1);
        send(2, 9'h1FF, 16'h0FFE, t0);
        drop(2);
        wait_drain();

        // Abort during data bit 3, then a fresh frame.
        send(0, 9'h0C3, model_frame(0, 9'h0C3), t0);
        drop(0);
        repeat (3) @(posedge baud_clk);
        @(negedge baud_clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_reset", {12'd0, busy_a[0], fd_a[0], rdy_a[0], line_a[0]}, 16'h0001);
        exp_q[0].delete();
        repeat (2) @(negedge baud_clk);
        rst = 1'b1;
        send(0, 9'h03C, 16'h0278, t0);
        drop(0);
        wait_drain();

        for (int g = 0; g < NCFG; g++) begin
            for (int i = 0; i < 15; i++) begin
                d = 9'($urandom_range(0, (1 << DW_A[g]) - 1));
                send(g, d, model_frame(g, d), t0);
                if ($urandom_range(0, 2) != 0) begin
                    drop(g);
                    repeat ($urandom_range(0, 12)) @(negedge baud_clk);
                end
            end
            drop(g);
        end
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
